// File: rtl/matmul_seq.sv
// matmul_seq: sequential signed matrix multiplier C = A*B
// reading A/B from a synchronous ROM and streaming C out row-major.
module matmul_seq #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int SELW = 2,
  parameter int AW   = SELW + 2 * $clog2(N),
  parameter int ACCW = 2 * DW + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SELW-1:0]       sel_a,
  input  logic [SELW-1:0]       sel_b,
  output logic [AW-1:0]         rom_a_addr,
  output logic [AW-1:0]         rom_b_addr,
  output logic                  rom_en,
  input  logic [DW-1:0]         rom_a_data,
  input  logic [DW-1:0]         rom_b_data,
  output logic [ACCW-1:0]       res_data,
  output logic [$clog2(N)-1:0]  res_row,
  output logic [$clog2(N)-1:0]  res_col,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t state, state_nx;

  logic [SELW-1:0] sa_q, sb_q;
  logic [CW-1:0]   i_q, j_q, k_q;
  logic            mac_v, mac_first;
  logic            last_k, last_j, last_el;

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] a_x, b_x, prod;

  assign last_k  = (k_q == CW'(N - 1));
  assign last_j  = (j_q == CW'(N - 1));
  assign last_el = last_j && (i_q == CW'(N - 1));

  assign a_x  = {{(ACCW-DW){rom_a_data[DW-1]}}, rom_a_data};
  assign b_x  = {{(ACCW-DW){rom_b_data[DW-1]}}, rom_b_data};
  assign prod = a_x * b_x;

  // k is parked at N-1 outside ISSUE, so addresses keep their last value
  assign rom_a_addr = AW'(sa_q) * AW'(N * N)
                    + AW'(i_q) * AW'(N) + AW'(k_q);
  assign rom_b_addr = AW'(sb_q) * AW'(N * N)
                    + AW'(k_q) * AW'(N) + AW'(j_q);

  assign res_data = acc;
  assign res_row  = i_q;
  assign res_col  = j_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (last_k) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_OUT;
      S_OUT: begin
        if (res_ready)
          state_nx = last_el ? S_FIN : S_ISSUE;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    rom_en    = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_ISSUE: rom_en    = 1'b1;
      S_OUT:   res_valid = 1'b1;
      S_FIN:   done      = 1'b1;
      default: ;
    endcase
  end

  // counters, latched selects and the MAC pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q      <= '0;
      sb_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      mac_v     <= 1'b0;
      mac_first <= 1'b0;
      acc       <= '0;
    end else begin
      mac_v     <= rom_en;
      mac_first <= rom_en && (k_q == '0);
      if (mac_v)
        acc <= mac_first ? prod : acc + prod;
      case (state)
        S_IDLE: begin
          if (start) begin
            sa_q <= sel_a;
            sb_q <= sel_b;
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            acc  <= '0;
          end
        end
        S_ISSUE: begin
          if (!last_k) k_q <= k_q + 1'b1;
        end
        S_OUT: begin
          if (res_ready && !last_el) begin
            k_q <= '0;
            if (last_j) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: randomized self-checking bench for matmul_seq,
// N=2 instance for function/handshake, N=4 instance for addressing.
module tb_matmul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        start2, en2, rv2, rdy2, busy2, done2;
  logic [1:0]  sa2, sb2;
  logic [3:0]  aa2, ba2;
  logic [7:0]  ad2, bd2;
  logic [16:0] rd2;
  logic [0:0]  rr2, rc2;

  logic        start4, en4, rv4, rdy4, busy4, done4;
  logic [1:0]  sa4, sb4;
  logic [5:0]  aa4, ba4;
  logic [7:0]  ad4, bd4;
  logic [17:0] rd4;
  logic [1:0]  rr4, rc4;

  logic signed [7:0] rom2 [16];
  logic signed [7:0] rom4 [64];

  matmul_seq #(.N(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .sel_a(sa2), .sel_b(sb2),
    .rom_a_addr(aa2), .rom_b_addr(ba2), .rom_en(en2),
    .rom_a_data(ad2), .rom_b_data(bd2),
    .res_data(rd2), .res_row(rr2), .res_col(rc2),
    .res_valid(rv2), .res_ready(rdy2),
    .busy(busy2), .done(done2)
  );

  matmul_seq #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .sel_a(sa4), .sel_b(sb4),
    .rom_a_addr(aa4), .rom_b_addr(ba4), .rom_en(en4),
    .rom_a_data(ad4), .rom_b_data(bd4),
    .res_data(rd4), .res_row(rr4), .res_col(rc4),
    .res_valid(rv4), .res_ready(rdy4),
    .busy(busy4), .done(done4)
  );

  // synchronous ROMs: data one cycle after rom_en
  always @(posedge clk) begin
    if (en2) begin
      ad2 <= rom2[aa2];
      bd2 <= rom2[ba2];
    end
    if (en4) begin
      ad4 <= rom4[aa4];
      bd4 <= rom4[ba4];
    end
  end

  int q2_d[$], q2_r[$], q2_c[$];
  int q4_d[$], q4_r[$], q4_c[$];

  // record every accepted result element
  always @(negedge clk) begin
    if (!rst && rv2 && rdy2) begin
      q2_d.push_back(int'($signed(rd2)));
      q2_r.push_back(int'(rr2));
      q2_c.push_back(int'(rc2));
    end
    if (!rst && rv4 && rdy4) begin
      q4_d.push_back(int'($signed(rd4)));
      q4_r.push_back(int'(rr4));
      q4_c.push_back(int'(rc4));
    end
  end

  function automatic int ref2(int sa, int sb, int r, int c);
    int s = 0;
    for (int k = 0; k < 2; k++)
      s += int'(rom2[sa*4 + r*2 + k]) * int'(rom2[sb*4 + k*2 + c]);
    return s;
  endfunction

  function automatic int ref4(int sa, int sb, int r, int c);
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += int'(rom4[sa*16 + r*4 + k]) * int'(rom4[sb*16 + k*4 + c]);
    return s;
  endfunction

  task automatic clear2();
    q2_d.delete(); q2_r.delete(); q2_c.delete();
  endtask

  task automatic kick2(input logic [1:0] a, input logic [1:0] b);
    @(posedge clk); #1;
    sa2 = a; sb2 = b; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic wait_done2(input int lim, input bit rnd,
                            output int cyc, output bit got);
    cyc = 1;
    got = 1'b0;
    while (cyc <= lim) begin
      @(negedge clk);
      if (done2) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (rnd) rdy2 = ($urandom_range(0, 3) != 0);
    end
    rdy2 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start2 = 0; start4 = 0; rdy2 = 1; rdy4 = 1;
    sa2 = 0; sb2 = 0; sa4 = 0; sb4 = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({en2, aa2, ba2, rv2, rd2, rr2, rc2, busy2, done2} !== '0) begin
      bad++;
      $display("FAIL reset_n2 got en=%b a=%h b=%h v=%b d=%h r=%h c=%h bz=%b dn=%b want all 0",
               en2, aa2, ba2, rv2, rd2, rr2, rc2, busy2, done2);
    end
    total++;
    if ({en4, aa4, ba4, rv4, rd4, rr4, rc4, busy4, done4} !== '0) begin
      bad++;
      $display("FAIL reset_n4 got en=%b a=%h b=%h v=%b d=%h bz=%b dn=%b want all 0",
               en4, aa4, ba4, rv4, rd4, busy4, done4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int cyc; bit got;
    clear2();
    kick2(2'd0, 2'd1);
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || cyc != 17) begin
      bad++;
      $display("FAIL ident_latency got=%0d seen=%0d want=17", cyc, got);
    end
    total++;
    if (busy2 !== 1'b1) begin
      bad++;
      $display("FAIL ident_busy_fin got=%b want=1", busy2);
    end
    @(negedge clk);
    total++;
    if ({busy2, done2} !== 2'b00) begin
      bad++;
      $display("FAIL ident_after_fin got=%b want=00", {busy2, done2});
    end
    total++;
    if (q2_d.size() != 4) begin
      bad++;
      $display("FAIL ident_count got=%0d want=4", q2_d.size());
    end
    for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
      total++;
      if (q2_r[e] != e/2 || q2_c[e] != e%2 || q2_d[e] != e + 1
          || q2_d[e] != ref2(0, 1, e/2, e%2)) begin
        bad++;
        $display("FAIL ident_elem%0d got=(%0d,%0d)=%0d want=(%0d,%0d)=%0d",
                 e, q2_r[e], q2_c[e], q2_d[e], e/2, e%2, e + 1);
      end
    end
  endtask

  task automatic test_negative();
    int cyc; bit got;
    clear2();
    kick2(2'd2, 2'd2);
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || q2_d.size() != 4) begin
      bad++;
      $display("FAIL neg_count got=%0d done=%0d want=4", q2_d.size(), got);
    end
    for (int e = 0; e < q2_d.size(); e++) begin
      total++;
      if (q2_d[e] != 32768) begin
        bad++;
        $display("FAIL neg_elem%0d got=%0d want=32768", e, q2_d[e]);
      end
    end
  endtask

  task automatic test_stall();
    int cyc, n; bit got;
    int exp01;
    clear2();
    rdy2 = 1'b0;
    kick2(2'd3, 2'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rv2 && rc2 == 1'b0) && n < 50);
    @(posedge clk); #1; rdy2 = 1'b1;
    @(posedge clk); #1; rdy2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv2 && n < 50);
    exp01 = ref2(3, 1, 0, 1);
    repeat (10) begin
      total++;
      if (rv2 !== 1'b1 || en2 !== 1'b0 || rr2 !== 1'b0 || rc2 !== 1'b1
          || int'($signed(rd2)) != exp01) begin
        bad++;
        $display("FAIL stall_hold got v=%b en=%b r=%b c=%b d=%0d want v=1 en=0 r=0 c=1 d=%0d",
                 rv2, en2, rr2, rc2, int'($signed(rd2)), exp01);
      end
      @(negedge clk);
    end
    @(posedge clk); #1; rdy2 = 1'b1;
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || q2_d.size() != 4) begin
      bad++;
      $display("FAIL stall_count got=%0d done=%0d want=4", q2_d.size(), got);
    end
    for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
      total++;
      if (q2_r[e] != e/2 || q2_c[e] != e%2
          || q2_d[e] != ref2(3, 1, e/2, e%2)) begin
        bad++;
        $display("FAIL stall_elem%0d got=%0d want=%0d",
                 e, q2_d[e], ref2(3, 1, e/2, e%2));
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc; bit got;
    clear2();
    kick2(2'd3, 2'd1);
    repeat (5) @(posedge clk);
    #1;
    sa2 = 2'd0; sb2 = 2'd2; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || q2_d.size() != 4) begin
      bad++;
      $display("FAIL ign_count got=%0d done=%0d want=4", q2_d.size(), got);
    end
    for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
      total++;
      if (q2_r[e] != e/2 || q2_c[e] != e%2
          || q2_d[e] != ref2(3, 1, e/2, e%2)) begin
        bad++;
        $display("FAIL ign_elem%0d got=%0d want=%0d",
                 e, q2_d[e], ref2(3, 1, e/2, e%2));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit got;
    clear2();
    kick2(2'd1, 2'd0);
    wait_done2(200, 1'b0, cyc, got);
    start2 = 1'b1;
    sa2 = 2'd2;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL fin_start_ignored busy got=%b want=0", busy2);
    end
    total++;
    if (q2_d.size() != 4 || q2_d[3] != ref2(1, 0, 1, 1)) begin
      bad++;
      $display("FAIL b2b_first_run n=%0d want=4", q2_d.size());
    end
    clear2();
    kick2(2'd1, 2'd3);
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || cyc != 17 || q2_d.size() != 4) begin
      bad++;
      $display("FAIL b2b_second got cyc=%0d n=%0d want cyc=17 n=4",
               cyc, q2_d.size());
    end
    for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
      total++;
      if (q2_d[e] != ref2(1, 3, e/2, e%2)) begin
        bad++;
        $display("FAIL b2b_elem%0d got=%0d want=%0d",
                 e, q2_d[e], ref2(1, 3, e/2, e%2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n; bit got;
    clear2();
    kick2(2'd1, 2'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(en2 && rr2 == 1'b1 && rc2 == 1'b0) && n < 50);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({en2, aa2, ba2, rv2, rd2, rr2, rc2, busy2, done2} !== '0) begin
      bad++;
      $display("FAIL midrst_zero got en=%b a=%h b=%h d=%h r=%b bz=%b want all 0",
               en2, aa2, ba2, rd2, rr2, busy2);
    end
    @(negedge clk);
    total++;
    if (done2 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_done got=%b want=0", done2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear2();
    kick2(2'd1, 2'd1);
    wait_done2(200, 1'b0, cyc, got);
    total++;
    if (!got || cyc != 17 || q2_d.size() != 4) begin
      bad++;
      $display("FAIL midrst_rerun got cyc=%0d n=%0d want cyc=17 n=4",
               cyc, q2_d.size());
    end
    for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
      total++;
      if (q2_r[e] != e/2 || q2_c[e] != e%2
          || q2_d[e] != ref2(1, 1, e/2, e%2)) begin
        bad++;
        $display("FAIL midrst_elem%0d got=%0d want=%0d",
                 e, q2_d[e], ref2(1, 1, e/2, e%2));
      end
    end
  endtask

  task automatic test_random();
    int cyc; bit got;
    logic [1:0] a, b;
    for (int it = 0; it < 6; it++) begin
      for (int x = 12; x < 16; x++) rom2[x] = 8'($urandom);
      a = 2'($urandom);
      b = 2'($urandom);
      clear2();
      kick2(a, b);
      wait_done2(2000, 1'b1, cyc, got);
      total++;
      if (!got || q2_d.size() != 4) begin
        bad++;
        $display("FAIL rnd%0d_count got=%0d done=%0d want=4",
                 it, q2_d.size(), got);
      end
      for (int e = 0; e < 4 && e < q2_d.size(); e++) begin
        total++;
        if (q2_r[e] != e/2 || q2_c[e] != e%2
            || q2_d[e] != ref2(a, b, e/2, e%2)) begin
          bad++;
          $display("FAIL rnd%0d_elem%0d got=%0d want=%0d",
                   it, e, q2_d[e], ref2(a, b, e/2, e%2));
        end
      end
    end
  endtask

  task automatic test_addr4();
    int cyc; bit got;
    q4_d.delete(); q4_r.delete(); q4_c.delete();
    @(posedge clk); #1;
    sa4 = 2'd2; sb4 = 2'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    total++;
    if (en4 !== 1'b1 || aa4 !== 6'd32 || ba4 !== 6'd48) begin
      bad++;
      $display("FAIL addr_k0 got en=%b a=%0d b=%0d want en=1 a=32 b=48",
               en4, aa4, ba4);
    end
    @(negedge clk);
    total++;
    if (aa4 !== 6'd33 || ba4 !== 6'd52) begin
      bad++;
      $display("FAIL addr_k1 got a=%0d b=%0d want a=33 b=52", aa4, ba4);
    end
    cyc = 2;
    got = 1'b0;
    while (cyc <= 300) begin
      if (done4) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!got || cyc != 97) begin
      bad++;
      $display("FAIL n4_latency got=%0d seen=%0d want=97", cyc, got);
    end
    total++;
    if (q4_d.size() != 16) begin
      bad++;
      $display("FAIL n4_count got=%0d want=16", q4_d.size());
    end
    for (int e = 0; e < 16 && e < q4_d.size(); e++) begin
      total++;
      if (q4_r[e] != e/4 || q4_c[e] != e%4
          || q4_d[e] != ref4(2, 3, e/4, e%4)) begin
        bad++;
        $display("FAIL n4_elem%0d got=(%0d,%0d)=%0d want=(%0d,%0d)=%0d",
                 e, q4_r[e], q4_c[e], q4_d[e], e/4, e%4, ref4(2, 3, e/4, e%4));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rom2[0] = 1;    rom2[1] = 0;    rom2[2] = 0;    rom2[3] = 1;
    rom2[4] = 1;    rom2[5] = 2;    rom2[6] = 3;    rom2[7] = 4;
    for (int x = 8; x < 12; x++) rom2[x] = -8'sd128;
    for (int x = 12; x < 16; x++) rom2[x] = 8'($urandom);
    for (int x = 0; x < 64; x++) rom4[x] = 8'($urandom);
    rom4[40] = -8'sd128;
    rom4[50] = -8'sd128;

    test_reset();
    test_identity();
    test_negative();
    test_stall();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_addr4();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
